// File: rtl/channel_animator.sv
// Frame-driven per-channel animator: walks every channel on a frame request, reads current and
// target values, steps them by the selected mode via a constant-time restoring divider, writes back.
module channel_animator #(
  parameter int unsigned c_ledboards = 30,
  parameter int unsigned c_bpc       = 12,
  parameter int unsigned c_max_time  = 1024,
  parameter int unsigned c_max_type  = 64,
  parameter int unsigned c_rd_lat    = 1,
  parameter int unsigned c_channels  = c_ledboards * 32,
  parameter int unsigned c_addr_w    = $clog2(c_channels),
  parameter int unsigned c_time_w    = $clog2(c_max_time),
  parameter int unsigned c_type_w    = $clog2(c_max_type)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_drq,
  input  logic [c_bpc-1:0]    i_current_data,
  input  logic [c_bpc-1:0]    i_target_data,
  input  logic [c_type_w-1:0] i_type,
  input  logic [c_time_w-1:0] i_start_time,
  input  logic [c_time_w-1:0] i_target_time,
  output logic [c_addr_w-1:0] o_addr,
  output logic                o_wen,
  output logic [c_bpc-1:0]    o_data,
  output logic                o_busy,
  output logic                o_drq
);

  localparam int unsigned DW    = c_bpc + 1;
  localparam int unsigned StepW = $clog2(c_bpc + c_rd_lat + 1);

  localparam logic [1:0] ModeCur = 2'd0;
  localparam logic [1:0] ModeTgt = 2'd1;
  localparam logic [1:0] ModeDiv = 2'd2;

  typedef enum logic [2:0] {StIdle, StAddr, StWait, StDiv, StWrite, StEnd} state_e;

  state_e              state_q, state_d;
  logic [c_time_w-1:0] cnt_q, cnt_d;
  logic [c_addr_w-1:0] addr_q, addr_d;
  logic [c_bpc-1:0]    data_q, data_d;
  logic [StepW-1:0]    step_q, step_d;
  logic [c_bpc-1:0]    cur_q, cur_d;
  logic [c_bpc-1:0]    tgt_q, tgt_d;
  logic                neg_q, neg_d;
  logic [DW-1:0]       quo_q, quo_d;
  logic [c_time_w-1:0] rem_q, rem_d;
  logic [c_time_w-1:0] div_q, div_d;
  logic [1:0]          mode_q, mode_d;
  logic                settled_q, settled_d;

  logic [DW-1:0]       diff;
  logic [c_time_w-1:0] win_pos, win_len, frames_left;
  logic [c_time_w:0]   trial, trial_sub;
  logic [DW-1:0]       quo_signed;
  logic [c_bpc-1:0]    div_out;

  assign diff        = {1'b0, i_target_data} - {1'b0, i_current_data};
  assign win_pos     = cnt_q - i_start_time;
  assign win_len     = i_target_time - i_start_time;
  assign frames_left = i_target_time - cnt_q;
  assign trial       = {rem_q, quo_q[DW-1]};
  assign trial_sub   = trial - {1'b0, div_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    step_d     = step_q;
    cur_d      = cur_q;
    tgt_d      = tgt_q;
    neg_d      = neg_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    div_d      = div_q;
    mode_d     = mode_q;
    settled_d  = settled_q;
    quo_signed = '0;
    div_out    = '0;

    unique case (state_q)
      StIdle: begin
        if (i_drq) begin
          state_d   = StAddr;
          cnt_d     = cnt_q + c_time_w'(1);
          addr_d    = '0;
          settled_d = 1'b1;
        end
      end
      StAddr: begin
        state_d = StWait;
        step_d  = '0;
      end
      StWait: begin
        step_d = step_q + StepW'(1);
        if (step_q == StepW'(c_rd_lat - 1)) begin
          state_d = StDiv;
          step_d  = '0;
          cur_d   = i_current_data;
          tgt_d   = i_target_data;
          neg_d   = diff[DW-1];
          quo_d   = diff[DW-1] ? -diff : diff;
          rem_d   = '0;
          div_d   = frames_left;
          if (win_pos > win_len) begin
            mode_d = ModeCur;
          end else if (i_type == c_type_w'(1)) begin
            mode_d = ModeTgt;
          end else if (i_type == c_type_w'(2)) begin
            mode_d = (frames_left == '0) ? ModeTgt : ModeDiv;
          end else begin
            mode_d = ModeCur;
          end
        end
      end
      StDiv: begin
        // One restoring step per cycle; runs full length regardless of mode.
        step_d = step_q + StepW'(1);
        if (trial >= {1'b0, div_q}) begin
          rem_d = trial_sub[c_time_w-1:0];
          quo_d = {quo_q[DW-2:0], 1'b1};
        end else begin
          rem_d = trial[c_time_w-1:0];
          quo_d = {quo_q[DW-2:0], 1'b0};
        end
        quo_signed = neg_q ? -quo_d : quo_d;
        div_out    = cur_q + quo_signed[c_bpc-1:0];
        if (step_q == StepW'(c_bpc)) begin
          state_d = StWrite;
          case (mode_q)
            ModeTgt: data_d = tgt_q;
            ModeDiv: data_d = div_out;
            default: data_d = cur_q;
          endcase
        end
      end
      StWrite: begin
        if (data_q != tgt_q) settled_d = 1'b0;
        if (addr_q == c_addr_w'(c_channels - 1)) begin
          state_d = StEnd;
        end else begin
          addr_d  = addr_q + c_addr_w'(1);
          state_d = StAddr;
        end
      end
      StEnd: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      step_q    <= '0;
      cur_q     <= '0;
      tgt_q     <= '0;
      neg_q     <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      mode_q    <= ModeCur;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      step_q    <= step_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      neg_q     <= neg_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      settled_q <= settled_d;
    end
  end

  assign o_addr = addr_q;
  assign o_data = data_q;
  assign o_wen  = (state_q == StWrite);
  assign o_busy = (state_q != StIdle);
  assign o_drq  = (state_q == StEnd) && settled_q;

endmodule
